// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - opcode/result-class encodings and divider FSM states for the EX stage
package ex_pkg;

   localparam logic [2:0] SEL_NOP   = 3'b000;
   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_ARITH = 3'b011;
   localparam logic [2:0] SEL_MOVE  = 3'b100;
   localparam logic [2:0] SEL_DIV   = 3'b101;

   localparam logic [7:0] OP_OR   = 8'h25;
   localparam logic [7:0] OP_AND  = 8'h24;
   localparam logic [7:0] OP_XOR  = 8'h26;
   localparam logic [7:0] OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C;
   localparam logic [7:0] OP_SRL  = 8'h02;
   localparam logic [7:0] OP_SRA  = 8'h03;
   localparam logic [7:0] OP_ADDU = 8'h21;
   localparam logic [7:0] OP_SUBU = 8'h23;
   localparam logic [7:0] OP_SLT  = 8'h2A;
   localparam logic [7:0] OP_SLTU = 8'h2B;
   localparam logic [7:0] OP_MFHI = 8'h10;
   localparam logic [7:0] OP_MTHI = 8'h11;
   localparam logic [7:0] OP_MFLO = 8'h12;
   localparam logic [7:0] OP_MTLO = 8'h13;
   localparam logic [7:0] OP_DIVU = 8'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } ex_state_e;

endpackage

// File: rtl/stage_ex_mc_if.sv
// rtl/stage_ex_mc_if.sv - ID/EX input slot and EX/MEM result bundle of the execute stage
interface stage_ex_mc_if #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
);
   logic               in_valid;
   logic [7:0]         aluop;
   logic [2:0]         alusel;
   logic [XLEN-1:0]    opv1;
   logic [XLEN-1:0]    opv2;
   logic               we;
   logic [RADDR_W-1:0] waddr;
   logic               stall_o;
   logic               out_valid;
   logic               we_o;
   logic [RADDR_W-1:0] waddr_o;
   logic [XLEN-1:0]    wdata;
   logic [XLEN-1:0]    hi_o;
   logic [XLEN-1:0]    lo_o;

   modport master (
      output in_valid, aluop, alusel, opv1, opv2, we, waddr,
      input  stall_o, out_valid, we_o, waddr_o, wdata, hi_o, lo_o
   );

   modport slave (
      input  in_valid, aluop, alusel, opv1, opv2, we, waddr,
      output stall_o, out_valid, we_o, waddr_o, wdata, hi_o, lo_o
   );
endinterface

// File: rtl/ex_divu_iter.sv
// rtl/ex_divu_iter.sv - iterative restoring unsigned divider, one quotient bit per cycle
module ex_divu_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quot,
   output logic [XLEN-1:0] rem
);
   localparam int CW = $clog2(XLEN) + 1;

   logic [XLEN-1:0] quot_q, rem_q, div_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic [XLEN:0]   shifted, trial;
   logic            fits;

   // quot_q doubles as the dividend shift register; its MSB feeds the partial remainder
   assign shifted = {rem_q, quot_q[XLEN-1]};
   assign trial   = shifted - {1'b0, div_q};
   assign fits    = shifted >= {1'b0, div_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         quot_q <= '0;
         rem_q  <= '0;
         div_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start) begin
         quot_q <= dividend;
         rem_q  <= '0;
         div_q  <= divisor;
         cnt_q  <= CW'(XLEN);
         busy_q <= 1'b1;
      end else if (busy_q) begin
         rem_q  <= fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
         quot_q <= {quot_q[XLEN-2:0], fits};
         cnt_q  <= cnt_q - 1'b1;
         if (cnt_q == CW'(1)) busy_q <= 1'b0;
      end
   end

   assign busy = busy_q;
   assign done = busy_q && (cnt_q == CW'(1));
   assign quot = quot_q;
   assign rem  = rem_q;
endmodule

// File: rtl/stage_ex_mc.sv
// rtl/stage_ex_mc.sv - execute stage with HI/LO registers; STAGE_EX_DIV_EN adds the stalling DIVU unit
module stage_ex_mc
   import ex_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic         clk,
   input  logic         rst,
   stage_ex_mc_if.slave bus
);
   localparam int SHW = $clog2(XLEN);

   logic               out_valid_q, out_valid_d;
   logic               we_q, we_d;
   logic [RADDR_W-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]    wdata_q, wdata_d;
   logic [XLEN-1:0]    hi_q, hi_d;
   logic [XLEN-1:0]    lo_q, lo_d;
   logic [XLEN-1:0]    result;
   logic [SHW-1:0]     shamt;
   logic               is_mthi, is_mtlo, accept;

   assign shamt   = bus.opv1[SHW-1:0];
   assign is_mthi = (bus.alusel == SEL_MOVE) && (bus.aluop == OP_MTHI);
   assign is_mtlo = (bus.alusel == SEL_MOVE) && (bus.aluop == OP_MTLO);

   always_comb begin
      result = '0;
      case (bus.alusel)
         SEL_LOGIC: begin
            case (bus.aluop)
               OP_OR:   result = bus.opv1 | bus.opv2;
               OP_AND:  result = bus.opv1 & bus.opv2;
               OP_XOR:  result = bus.opv1 ^ bus.opv2;
               OP_NOR:  result = ~(bus.opv1 | bus.opv2);
               default: result = '0;
            endcase
         end
         SEL_SHIFT: begin
            case (bus.aluop)
               OP_SLL:  result = bus.opv2 << shamt;
               OP_SRL:  result = bus.opv2 >> shamt;
               OP_SRA:  result = $signed(bus.opv2) >>> shamt;
               default: result = '0;
            endcase
         end
         SEL_ARITH: begin
            case (bus.aluop)
               OP_ADDU: result = bus.opv1 + bus.opv2;
               OP_SUBU: result = bus.opv1 - bus.opv2;
               OP_SLT:  result = XLEN'($signed(bus.opv1) < $signed(bus.opv2));
               OP_SLTU: result = XLEN'(bus.opv1 < bus.opv2);
               default: result = '0;
            endcase
         end
         SEL_MOVE: begin
            case (bus.aluop)
               OP_MFHI: result = hi_q;
               OP_MFLO: result = lo_q;
               default: result = '0;
            endcase
         end
         default: result = '0;
      endcase
   end

`ifdef STAGE_EX_DIV_EN
   ex_state_e       state_q, state_d;
   logic            stall, div_start, div_busy, div_done, is_divu;
   logic [XLEN-1:0] div_quot, div_rem;

   assign is_divu = (bus.alusel == SEL_DIV) && (bus.aluop == OP_DIVU);

   ex_divu_iter #(.XLEN(XLEN)) u_divu (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (bus.opv1),
      .divisor  (bus.opv2),
      .busy     (div_busy),
      .done     (div_done),
      .quot     (div_quot),
      .rem      (div_rem)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end
`endif

   always_comb begin
      out_valid_d = 1'b0;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      accept      = bus.in_valid;
`ifdef STAGE_EX_DIV_EN
      state_d   = state_q;
      stall     = 1'b0;
      div_start = 1'b0;
      // DIVU stays on the inputs through DONE, where it retires instead of being re-issued
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && is_divu) begin
               accept    = 1'b0;
               stall     = 1'b1;
               div_start = 1'b1;
               state_d   = ST_DIV;
            end
         end
         ST_DIV: begin
            accept = 1'b0;
            stall  = 1'b1;
            if (div_done || !div_busy) state_d = ST_DONE;
         end
         ST_DONE: begin
            accept      = 1'b0;
            out_valid_d = 1'b1;
            hi_d        = div_rem;
            lo_d        = div_quot;
            state_d     = ST_IDLE;
         end
         default: begin
            accept  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
`endif
      if (accept) begin
         out_valid_d = 1'b1;
         we_d        = bus.we && !(is_mthi || is_mtlo);
         waddr_d     = bus.waddr;
         wdata_d     = result;
         if (is_mthi) hi_d = bus.opv1;
         if (is_mtlo) lo_d = bus.opv1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
      end
   end

`ifdef STAGE_EX_DIV_EN
   assign bus.stall_o = stall;
`else
   assign bus.stall_o = 1'b0;
`endif
   assign bus.out_valid = out_valid_q;
   assign bus.we_o      = we_q;
   assign bus.waddr_o   = waddr_q;
   assign bus.wdata     = wdata_q;
   assign bus.hi_o      = hi_q;
   assign bus.lo_o      = lo_q;
endmodule

// File: tb/tb_stage_ex_mc.sv
// tb/tb_stage_ex_mc.sv - directed bench for stage_ex_mc at XLEN 32 and 16; STAGE_EX_DIV_EN selects divider checks
module tb_stage_ex_mc;
   import ex_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   vec_n = 0;

   always #5 clk = ~clk;

   stage_ex_mc_if #(.XLEN(32), .RADDR_W(5)) b32 ();
   stage_ex_mc_if #(.XLEN(16), .RADDR_W(5)) b16 ();

   stage_ex_mc #(.XLEN(32), .RADDR_W(5)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
   stage_ex_mc #(.XLEN(16), .RADDR_W(5)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b32.in_valid = 1'b0;
      b16.in_valid = 1'b0;
   endtask

   task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic w, input logic [4:0] wa, input bit both);
      b32.in_valid = 1'b1;  b32.aluop = op;  b32.alusel = sel;
      b32.opv1 = a;         b32.opv2 = b;    b32.we = w;  b32.waddr = wa;
      b16.in_valid = both;  b16.aluop = op;  b16.alusel = sel;
      b16.opv1 = a[15:0];   b16.opv2 = b[15:0]; b16.we = w; b16.waddr = wa;
   endtask

   task automatic run_vec(input string tag, input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e32, input logic [15:0] e16);
      logic [4:0] wa;
      vec_n++;
      wa = 5'(vec_n);
      drive(op, sel, a, b, 1'b1, wa, 1'b1);
      step();
      idle();
      check({tag, " wdata32"}, b32.wdata, e32);
      check({tag, " wdata16"}, {16'h0, b16.wdata}, {16'h0, e16});
      check({tag, " we_o"}, {31'h0, b32.we_o}, 32'h1);
      check({tag, " waddr_o"}, {27'h0, b32.waddr_o}, {27'h0, wa});
      check({tag, " out_valid"}, {31'h0, b32.out_valid}, 32'h1);
   endtask

`ifdef STAGE_EX_DIV_EN
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] prev_lo, input logic [31:0] exp_q, input logic [31:0] exp_r);
      int n;
      n = 0;
      drive(OP_DIVU, SEL_DIV, a, b, 1'b1, 5'd7, 1'b0);
      while (b32.stall_o === 1'b1 && n < 200) begin
         n++;
         step();
      end
      check({tag, " stall cycles"}, n, 32'd33);
      check({tag, " lo before done"}, b32.lo_o, prev_lo);
      idle();
      step();
      check({tag, " lo"}, b32.lo_o, exp_q);
      check({tag, " hi"}, b32.hi_o, exp_r);
      check({tag, " out_valid"}, {31'h0, b32.out_valid}, 32'h1);
      check({tag, " we_o"}, {31'h0, b32.we_o}, 32'h0);
   endtask
`endif

   initial begin
      rst = 1'b1;
      drive(8'h0, 3'h0, 32'h0, 32'h0, 1'b0, 5'h0, 1'b0);
      idle();
      step();
      step();
      check("rst out_valid", {31'h0, b32.out_valid}, 32'h0);
      check("rst we_o", {31'h0, b32.we_o}, 32'h0);
      check("rst waddr_o", {27'h0, b32.waddr_o}, 32'h0);
      check("rst wdata", b32.wdata, 32'h0);
      check("rst hi", b32.hi_o, 32'h0);
      check("rst lo", b32.lo_o, 32'h0);
      check("rst stall", {31'h0, b32.stall_o}, 32'h0);
      check("rst wdata16", {16'h0, b16.wdata}, 32'h0);
      rst = 1'b0;

      run_vec("or",     OP_OR,   SEL_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000, 32'h0F0F_F0F0, 16'hF0F0);
      run_vec("and",    OP_AND,  SEL_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 16'h0F00);
      run_vec("xor",    OP_XOR,  SEL_LOGIC, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 16'hFF00);
      run_vec("nor",    OP_NOR,  SEL_LOGIC, 32'h0000_000F, 32'h0000_00F0, 32'hFFFF_FF00, 16'hFF00);
      run_vec("addu",   OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 16'h0001);
      run_vec("subu",   OP_SUBU, SEL_ARITH, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 16'hFFFF);
      run_vec("slt",    OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 16'h0001);
      run_vec("sltu",   OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 16'h0000);
      run_vec("sll",    OP_SLL,  SEL_SHIFT, 32'h0000_0008, 32'h0000_0001, 32'h0000_0100, 16'h0100);
      run_vec("srl",    OP_SRL,  SEL_SHIFT, 32'h0000_0004, 32'h8000_8000, 32'h0800_0800, 16'h0800);
      run_vec("sra",    OP_SRA,  SEL_SHIFT, 32'h0000_0004, 32'h8000_8000, 32'hF800_0800, 16'hF800);
      run_vec("sra_hi", OP_SRA,  SEL_SHIFT, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 16'h0000);
      run_vec("shmask", OP_SLL,  SEL_SHIFT, 32'h0000_0024, 32'h0000_0001, 32'h0000_0010, 16'h0010);
      run_vec("badsel", OP_OR,   3'b111,    32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 16'h0000);
      run_vec("badop",  OP_ADDU, SEL_LOGIC, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 16'h0000);

      drive(OP_MTHI, SEL_MOVE, 32'h0000_1234, 32'h0, 1'b1, 5'd3, 1'b1);
      step();
      check("mthi we_o", {31'h0, b32.we_o}, 32'h0);
      check("mthi we_o16", {31'h0, b16.we_o}, 32'h0);
      check("mthi out_valid", {31'h0, b32.out_valid}, 32'h1);
      check("mthi hi", b32.hi_o, 32'h0000_1234);
      check("mthi hi16", {16'h0, b16.hi_o}, 32'h0000_1234);
      drive(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 1'b1, 5'd4, 1'b1);
      step();
      check("mfhi wdata", b32.wdata, 32'h0000_1234);
      check("mfhi wdata16", {16'h0, b16.wdata}, 32'h0000_1234);
      check("mfhi we_o", {31'h0, b32.we_o}, 32'h1);
      drive(OP_MTLO, SEL_MOVE, 32'h0000_ABCD, 32'h0, 1'b1, 5'd5, 1'b1);
      step();
      check("mtlo lo", b32.lo_o, 32'h0000_ABCD);
      drive(OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 1'b1, 5'd6, 1'b1);
      step();
      idle();
      check("mflo wdata", b32.wdata, 32'h0000_ABCD);
      check("mflo wdata16", {16'h0, b16.wdata}, 32'h0000_ABCD);
      check("mflo hi kept", b32.hi_o, 32'h0000_1234);

      step();
      check("idle out_valid", {31'h0, b32.out_valid}, 32'h0);
      check("idle we_o", {31'h0, b32.we_o}, 32'h0);
      check("idle wdata hold", b32.wdata, 32'h0000_ABCD);

`ifdef STAGE_EX_DIV_EN
      run_div("div100_7", 32'd100, 32'd7, 32'h0000_ABCD, 32'd14, 32'd2);
      run_div("div5_0", 32'd5, 32'd0, 32'd14, 32'hFFFF_FFFF, 32'd5);

      drive(OP_DIVU, SEL_DIV, 32'd100, 32'd7, 1'b1, 5'd8, 1'b0);
      repeat (11) step();
      check("abort stall before rst", {31'h0, b32.stall_o}, 32'h1);
      rst = 1'b1;
      idle();
      step();
      check("abort stall", {31'h0, b32.stall_o}, 32'h0);
      check("abort hi", b32.hi_o, 32'h0);
      check("abort lo", b32.lo_o, 32'h0);
      check("abort out_valid", {31'h0, b32.out_valid}, 32'h0);
      rst = 1'b0;
      step();
      check("abort stays idle", {31'h0, b32.stall_o}, 32'h0);
`else
      drive(OP_DIVU, SEL_DIV, 32'd100, 32'd7, 1'b1, 5'd9, 1'b1);
      #1;
      check("nodiv stall issue", {31'h0, b32.stall_o}, 32'h0);
      step();
      idle();
      check("nodiv stall", {31'h0, b32.stall_o}, 32'h0);
      check("nodiv wdata", b32.wdata, 32'h0);
      check("nodiv wdata16", {16'h0, b16.wdata}, 32'h0);
      check("nodiv we_o", {31'h0, b32.we_o}, 32'h1);
      check("nodiv hi", b32.hi_o, 32'h0000_1234);
      check("nodiv lo", b32.lo_o, 32'h0000_ABCD);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
